// File: rtl/mult32x32_fast_fsm.sv
// mult32x32_fast_fsm: control sequencer for the fast 32x32 multiplier.
// Steps through the 16x16 partial products A0B0, A0B1, A1B0, A1B1 and skips
// any product whose MSW operand word was zero when the multiply started.
// This gives 1, 2 or 4 product cycles per operation.
// Optional build macro MULT_FSM_STATS_EN adds the ops_cnt/skip_cnt
// saturating statistics counters.
//
// Handshake: start is sampled only in IDLE. An accepted start clears the
// product register in the same cycle (clr_prod). busy stays high for every
// product cycle. done pulses for one cycle, in the first IDLE cycle after the
// last product cycle. A start in that cycle is accepted. A start while busy
// is dropped.
module mult32x32_fast_fsm #(
  parameter int unsigned SKIP_ZERO_MSW = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a_msw_is_0,
  input  logic             b_msw_is_0,
  output logic             busy,
  output logic             done,
  output logic             a_sel,
  output logic             b_sel,
  output logic [1:0]       shift_sel,
  output logic             upd_prod,
  output logic             clr_prod,
  output logic [2:0]       dbg_state
`ifdef MULT_FSM_STATS_EN
  ,
  output logic [CNT_W-1:0] ops_cnt,
  output logic [CNT_W-1:0] skip_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P00  = 3'd1,
    S_P01  = 3'd2,
    S_P10  = 3'd3,
    S_P11  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_az;
  logic   r_bz;
  logic   r_done;
  logic   w_accept;
  logic   w_last;
  logic   w_skip_en;

  assign w_skip_en = (SKIP_ZERO_MSW != 0);
  assign done      = r_done;
  assign dbg_state = r_state;

  // Next-state and output decode; product states are Moore, clr_prod is Mealy in IDLE
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = 2'd0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A start coinciding with reset is not accepted, so it must not clear either
        if (start && !reset) begin
          clr_prod = 1'b1;
          w_accept = 1'b1;
          w_next   = S_P00;
        end
      end
      S_P00: begin
        busy     = 1'b1;
        upd_prod = 1'b1;
        if (!w_skip_en || !r_bz) begin
          w_next = S_P01;
        end else if (!r_az) begin
          w_next = S_P10;
        end else begin
          w_next = S_IDLE;
          w_last = 1'b1;
        end
      end
      S_P01: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'd1;
        if (!w_skip_en || !r_az) begin
          w_next = S_P10;
        end else begin
          w_next = S_IDLE;
          w_last = 1'b1;
        end
      end
      S_P10: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        shift_sel = 2'd1;
        if (!w_skip_en || !r_bz) begin
          w_next = S_P11;
        end else begin
          w_next = S_IDLE;
          w_last = 1'b1;
        end
      end
      S_P11: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'd2;
        w_next    = S_IDLE;
        w_last    = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register, operand-flag latches and registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_az    <= 1'b0;
      r_bz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      if (w_accept) begin
        r_az <= a_msw_is_0;
        r_bz <= b_msw_is_0;
      end
    end
  end

`ifdef MULT_FSM_STATS_EN
  logic [1:0]     w_skipped;
  logic [CNT_W:0] w_skip_sum;

  // Products skipped by the operation now finishing. The flags still hold that
  // operation's values here, even when a new start lands in the done cycle.
  always_comb begin
    w_skipped = 2'd0;
    if (w_skip_en) begin
      if (r_az && r_bz) begin
        w_skipped = 2'd3;
      end else if (r_az ^ r_bz) begin
        w_skipped = 2'd2;
      end
    end
  end

  assign w_skip_sum = {1'b0, skip_cnt} + (CNT_W+1)'(w_skipped);

  // Saturating statistics counters, advanced once per done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_cnt  <= '0;
      skip_cnt <= '0;
    end else if (r_done) begin
      if (ops_cnt != '1) begin
        ops_cnt <= ops_cnt + CNT_W'(1);
      end
      if (w_skip_sum[CNT_W]) begin
        skip_cnt <= '1;
      end else begin
        skip_cnt <= w_skip_sum[CNT_W-1:0];
      end
    end
  end
`else
  // CNT_W only sizes the statistics counters; this tie-off keeps it referenced
  logic [CNT_W-1:0] w_unused_cnt_w;
  assign w_unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
// tb_mult32x32_fast_fsm: randomized and directed bench for the multiplier FSM.
// The reference model queues the partial products each accepted operation
// needs. A small arithmetic stand-in turns the FSM controls into a 64-bit
// product, which is compared against a*b.
module tb_mult32x32_fast_fsm;

  localparam int unsigned CNT_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_op;
  logic [31:0] b_op;
  logic        a_msw_is_0;
  logic        b_msw_is_0;
  logic        busy;
  logic        done;
  logic        a_sel;
  logic        b_sel;
  logic [1:0]  shift_sel;
  logic        upd_prod;
  logic        clr_prod;
  logic [2:0]  dbg_state;
`ifdef MULT_FSM_STATS_EN
  logic [CNT_W-1:0] ops_cnt;
  logic [CNT_W-1:0] skip_cnt;
`endif

  assign a_msw_is_0 = (a_op[31:16] == 16'd0);
  assign b_msw_is_0 = (b_op[31:16] == 16'd0);

  mult32x32_fast_fsm #(.SKIP_ZERO_MSW(1), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a_msw_is_0 (a_msw_is_0),
    .b_msw_is_0 (b_msw_is_0),
    .busy       (busy),
    .done       (done),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .shift_sel  (shift_sel),
    .upd_prod   (upd_prod),
    .clr_prod   (clr_prod),
    .dbg_state  (dbg_state)
`ifdef MULT_FSM_STATS_EN
    ,
    .ops_cnt    (ops_cnt),
    .skip_cnt   (skip_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected queue: one entry {a_sel, b_sel, shift[1:0]} per remaining product cycle
  logic [3:0]  exp_q[$];
  bit          m_done = 1'b0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  logic [63:0] prod_emul = '0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) r[31:16] = 16'd0;
    return r;
  endfunction

  // Compare against the model, emulate the arithmetic unit, then advance the model
  always @(negedge clk) begin : p_cmp
    logic [3:0]  e;
    logic [15:0] ah;
    logic [15:0] bh;
    bit          az;
    bit          bz;
    if (chk_en) begin
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("busy", busy, 1);
        chk("upd_prod", upd_prod, 1);
        chk("clr_prod", clr_prod, 0);
        chk("a_sel", a_sel, e[3]);
        chk("b_sel", b_sel, e[2]);
        chk("shift_sel", shift_sel, e[1:0]);
      end else begin
        chk("busy", busy, 0);
        chk("upd_prod", upd_prod, 0);
        chk("clr_prod", clr_prod, (start && !reset));
        chk("a_sel", a_sel, 0);
        chk("b_sel", b_sel, 0);
        chk("shift_sel", shift_sel, 0);
      end
      chk("done", done, m_done);
      if (m_done) chk("product", prod_emul, {32'd0, m_a} * {32'd0, m_b});
    end
    if (clr_prod) begin
      prod_emul = '0;
    end else if (upd_prod) begin
      ah = a_sel ? a_op[31:16] : a_op[15:0];
      bh = b_sel ? b_op[31:16] : b_op[15:0];
      prod_emul = prod_emul + (({48'd0, ah} * {48'd0, bh}) << (16 * shift_sel));
    end
    if (reset) begin
      exp_q.delete();
      m_done = 1'b0;
      chk_en = 1'b1;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      m_done = (exp_q.size() == 0);
    end else begin
      m_done = 1'b0;
      if (start) begin
        az = (a_op[31:16] == 16'd0);
        bz = (b_op[31:16] == 16'd0);
        exp_q.push_back(4'b0000);
        if (!bz) exp_q.push_back(4'b0101);
        if (!az) exp_q.push_back(4'b1001);
        if (!az && !bz) exp_q.push_back(4'b1110);
        m_a = a_op;
        m_b = b_op;
      end
    end
  end

  // Driver: one operation from idle; checks cycles from start to done
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input string name);
    int cnt;
    @(posedge clk); #2;
    a_op  = a;
    b_op  = b;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cnt   = 1;
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #2;
      cnt++;
    end
    chk(name, cnt, exp_lat);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin : p_main
    int ndone;
    reset = 1'b1;
    start = 1'b0;
    a_op  = '0;
    b_op  = '0;
    idle_cycles(3);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_clr", clr_prod, 0);
    chk("reset_upd", upd_prod, 0);
    reset = 1'b0;
    idle_cycles(2);

    // Directed latencies for each skip pattern
    run_op(32'h0000_1234, 32'h0000_5678, 2, "lat_n1");
    run_op(32'h0000_1234, 32'h9ABC_DEF0, 3, "lat_a_zero");
    run_op(32'h1234_5678, 32'h0000_DEF0, 3, "lat_b_zero");
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 5, "lat_n4");
    chk("product_literal", prod_emul, 64'h0B00_EA4E_242D_2080);
    idle_cycles(2);

`ifdef MULT_FSM_STATS_EN
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    run_op(32'h0000_0001, 32'h0000_0002, 2, "stats_n1");
    run_op(32'h0001_0001, 32'h0000_0002, 3, "stats_n2");
    run_op(32'h0001_0001, 32'h0001_0002, 5, "stats_n4");
    idle_cycles(1);
    chk("ops_cnt", ops_cnt, 3);
    chk("skip_cnt", skip_cnt, 5);
`endif

    // start held high: a new op is accepted only in each done cycle
    a_op  = 32'hFFFF_FFFF;
    b_op  = 32'h8000_0001;
    start = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clk); #2;
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    chk("start_held_dones", ndone, 5);
    idle_cycles(6);

    // Reset while in P01: back to IDLE on the next edge with no done pulse
    @(posedge clk); #2;
    a_op  = 32'h1111_2222;
    b_op  = 32'h3333_4444;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    idle_cycles(1);
    chk("p01_b_sel", b_sel, 1);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_upd", upd_prod, 0);
    chk("rst_shift", shift_sel, 0);
    ndone = 0;
    repeat (6) begin
      if (done === 1'b1) ndone++;
      @(posedge clk); #2;
    end
    chk("rst_no_done", ndone, 0);

    // Randomized traffic; operands change only while the model is idle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      if (exp_q.size() == 0) begin
        a_op = rand_op();
        b_op = rand_op();
      end
    end
    reset = 1'b0;
    start = 1'b0;
    idle_cycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog bound on the whole run
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
